image_rom_arbiter: RTL and testbench
====================================

Name: image_rom_arbiter

Overview:
- Shares one synchronous image ROM (12-bit address, 12-bit RGB, one-cycle registered read) between two pixel requesters, e.g. the two player-sprite draw pipelines.
- Each requester uses a valid/ready request handshake and gets its own response strobe.
- Arbitration is round-robin, so a requester that holds its request continuously cannot starve the other.
- Sits between the draw pipelines and the image_rom instance; the ROM itself is unchanged.

Parameters:
- ADDR_W, 12, ROM address width ({addry[5:0], addrx[5:0]}).
- DATA_W, 12, ROM data width (RGB 4:4:4).
- ROM_LAT, 1, ROM read latency in clocks; sets the depth of the tag pipeline.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an address
- req0_addr  in  ADDR_W  requester 0 address
- req0_ready  out  1  requester 0 accepted this cycle
- rsp0_valid  out  1  requester 0 data valid (one-cycle strobe)
- rsp0_rgb  out  DATA_W  requester 0 data
- req1_valid  in  1  requester 1 has an address
- req1_addr  in  ADDR_W  requester 1 address
- req1_ready  out  1  requester 1 accepted this cycle
- rsp1_valid  out  1  requester 1 data valid
- rsp1_rgb  out  DATA_W  requester 1 data
- rom_address  out  ADDR_W  to ROM address input
- rom_rgb  in  DATA_W  from ROM registered output

Behaviour:
- Reset (rst=1 at posedge):
  - last_grant := 1, so requester 0 wins the first tie.
  - Tag pipeline cleared.
  - rsp0_valid = rsp1_valid = 0; rsp0_rgb = rsp1_rgb = 0.
  - Address hold register := 0.
  - In-flight reads are dropped; no response is ever issued for them.
- Grant logic (combinational, at most one grant per cycle):
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready = grantN; ready never asserts without valid.
- On any grant at posedge, last_grant := granted id.
- No grant: last_grant holds.
- A request is accepted in cycle N when reqN_valid & reqN_ready.
- reqN_addr must be stable only in the accept cycle.
- rom_address:
  - Granted requester's address in cycle N (combinational mux).
  - With no grant, the hold register value (address of the last grant), so the ROM input does not toggle needlessly.
  - The hold register updates on every grant.
- Tag pipeline: ROM_LAT stages of {valid, id}.
  - Stage 0 loads {grant_any, granted id} at the posedge ending cycle N.
  - Stage ROM_LAT-1 aligns with rom_rgb.
- Response register:
  - When the final tag is valid with id k, the next posedge sets rspk_valid := 1 and rspk_rgb := rom_rgb.
  - The other rsp_valid := 0.
  - rsp_rgb of the idle requester holds its previous value.
- Latency: accept in cycle N gives a response in cycle N+ROM_LAT+1 (= N+2 by default).
- Throughput: one read per clock.
- Responses per requester return in acceptance order.
- Responses have no backpressure; consumers must sample rspN_rgb on the strobe.
- Fairness: with both valid every cycle, grants alternate 0,1,0,1,...
- Worst-case wait while holding valid is 1 cycle.
- Simultaneous rst and valid: rst wins; no grant takes effect and ready is forced 0 during reset.

Decomposition:
- Shared package image_rom_pkg:
  - Constants ROM_ADDR_W=12 and ROM_DATA_W=12.
  - typedef req_id_t (1 bit).
  - typedef rom_tag_t {valid, req_id_t id}.
- One sub-module: rr_arbiter2.
  - Inputs: clk, rst, two valids.
  - Outputs: one-hot grant, granted id.
  - Owns the last_grant register.
- Tag pipeline, address hold and response registers stay in image_rom_arbiter.

Test Plan:
- Reset then idle: rst high 2 cycles, no valids -> all ready/rsp_valid 0, rom_address=0, rsp rgb=0.
- Single requester:
  - Stimulus: req0 valid with addr 0x041 in cycle 5 (ROM model: rgb=addr^0xFFF).
  - Required: req0_ready=1 in cycle 5, rom_address=0x041 in cycle 5, rsp0_valid=1 with rsp0_rgb=0xFBE in cycle 7, rsp1_valid stays 0.
- Contention:
  - Stimulus: both valid continuously for 6 cycles with addrs 0x100/0x200.
  - Required: grants go 0,1,0,1,0,1; responses alternate starting 2 cycles after the first grant; each rgb matches its requester's address.
- Streaming:
  - Stimulus: req1 alone, back-to-back addresses 0..7.
  - Required: ready every cycle, 8 consecutive rsp1_valid strobes with in-order data.
  - Required: rom_address holds at 7 after the stream ends.
- Reset mid-flight:
  - Stimulus: accept req0 addr 0x0AA, assert rst the next cycle.
  - Required: no rsp0_valid ever for 0x0AA.
  - Required: after reset, simultaneous requests grant requester 0 first.

Source files
------------

// File: rtl/image_rom_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// image_rom_pkg
// Shared types and constants for the image ROM arbiter slice.
//   ROM_ADDR_W / ROM_DATA_W : geometry of the image ROM ({y[5:0],x[5:0]} -> RGB444)
//   req_id_t                : requester identifier (0 or 1)
//   rom_tag_t               : {valid, id} tag travelling alongside a ROM read
// -----------------------------------------------------------------------------
package image_rom_pkg;

    localparam int ROM_ADDR_W = 12;
    localparam int ROM_DATA_W = 12;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rom_tag_t;

    localparam rom_tag_t TAG_IDLE = '{valid: 1'b0, id: 1'b0};

    // One-hot grant vector for a requester id.
    function automatic logic [1:0] id_to_onehot(input req_id_t id);
        logic [1:0] oh;
        if (id == 1'b1) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/image_rom_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. Grant is combinational from the current valids
// and the last granted id; ties go to the requester that did not win last.
//   clk, rst      : clock, synchronous active-high reset
//   valid0_i/1_i  : request valids
//   grant_o       : one-hot grant (all zero when idle or in reset)
//   gnt_id_o      : id of the granted requester (meaningful when grant_o != 0)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import image_rom_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid0_i,
    input  logic       valid1_i,
    output logic [1:0] grant_o,
    output req_id_t    gnt_id_o
);

    req_id_t    last_grant_q;
    req_id_t    last_grant_d;
    logic [1:0] grant_s;
    req_id_t    gnt_id_s;

    // Grant selection; reset suppresses every grant so ready stays low.
    always_comb begin
        grant_s  = 2'b00;
        gnt_id_s = 1'b0;
        if (rst) begin
            grant_s  = 2'b00;
            gnt_id_s = 1'b0;
        end else if (valid0_i && valid1_i) begin
            gnt_id_s = ~last_grant_q;
            grant_s  = id_to_onehot(~last_grant_q);
        end else if (valid0_i) begin
            gnt_id_s = 1'b0;
            grant_s  = 2'b01;
        end else if (valid1_i) begin
            gnt_id_s = 1'b1;
            grant_s  = 2'b10;
        end else begin
            grant_s  = 2'b00;
            gnt_id_s = 1'b0;
        end
    end

    // Remember the winner; hold when nobody was granted.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_s != 2'b00) begin
            last_grant_d = gnt_id_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_o  = grant_s;
    assign gnt_id_o = gnt_id_s;

endmodule

// File: rtl/image_rom_arbiter.sv
// -----------------------------------------------------------------------------
// image_rom_arbiter
// Shares one synchronous image ROM between two pixel requesters with
// round-robin arbitration. A read accepted in cycle N returns in cycle
// N+ROM_LAT+1 as a one-cycle strobe on the owning requester's response port.
//   req{0,1}_valid/addr/ready : request handshake (accept = valid & ready)
//   rsp{0,1}_valid/rgb        : response strobe and data (no backpressure)
//   rom_address / rom_rgb     : to / from the image_rom instance
// -----------------------------------------------------------------------------
module image_rom_arbiter
    import image_rom_pkg::*;
#(
    parameter int ADDR_W  = ROM_ADDR_W,
    parameter int DATA_W  = ROM_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rgb,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rgb,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_rgb
);

    logic [1:0]        grant_s;
    req_id_t           gnt_id_s;
    logic              gnt_any_s;
    logic [ADDR_W-1:0] gnt_addr_s;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [ADDR_W-1:0] addr_hold_d;
    rom_tag_t          tag_q [ROM_LAT];
    rom_tag_t          tag_d [ROM_LAT];
    rom_tag_t          tag_out_s;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rgb_q, rsp0_rgb_d;
    logic [DATA_W-1:0] rsp1_rgb_q, rsp1_rgb_d;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .grant_o  (grant_s),
        .gnt_id_o (gnt_id_s)
    );

    assign gnt_any_s  = |grant_s;
    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];

    // Address mux; when idle the ROM keeps seeing the last granted address.
    always_comb begin
        gnt_addr_s  = req0_addr;
        addr_hold_d = addr_hold_q;
        rom_address = addr_hold_q;
        if (gnt_id_s == 1'b1) begin
            gnt_addr_s = req1_addr;
        end else begin
            gnt_addr_s = req0_addr;
        end
        if (gnt_any_s) begin
            addr_hold_d = gnt_addr_s;
            rom_address = gnt_addr_s;
        end else begin
            addr_hold_d = addr_hold_q;
            rom_address = addr_hold_q;
        end
    end

    // Tag shift: stage 0 captures this cycle's grant, last stage lines up with rom_rgb.
    always_comb begin
        for (int i = 0; i < ROM_LAT; i++) begin
            tag_d[i] = tag_q[i];
        end
        tag_d[0] = '{valid: gnt_any_s, id: gnt_id_s};
        for (int i = 1; i < ROM_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign tag_out_s = tag_q[ROM_LAT-1];

    // Route ROM data to the owner of the returning tag; the idle side keeps its data.
    always_comb begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rgb_d   = rsp0_rgb_q;
        rsp1_rgb_d   = rsp1_rgb_q;
        if (tag_out_s.valid && (tag_out_s.id == 1'b0)) begin
            rsp0_valid_d = 1'b1;
            rsp0_rgb_d   = rom_rgb;
        end else if (tag_out_s.valid && (tag_out_s.id == 1'b1)) begin
            rsp1_valid_d = 1'b1;
            rsp1_rgb_d   = rom_rgb;
        end else begin
            rsp0_valid_d = 1'b0;
            rsp1_valid_d = 1'b0;
        end
    end

    // State registers; reset empties the tag pipe so in-flight reads never respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold_q  <= {ADDR_W{1'b0}};
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_q[i] <= TAG_IDLE;
            end
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rgb_q   <= {DATA_W{1'b0}};
            rsp1_rgb_q   <= {DATA_W{1'b0}};
        end else begin
            addr_hold_q  <= addr_hold_d;
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rgb_q   <= rsp0_rgb_d;
            rsp1_rgb_q   <= rsp1_rgb_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rgb   = rsp0_rgb_q;
    assign rsp1_rgb   = rsp1_rgb_q;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_image_rom_arbiter
// Directed bench with a per-requester scoreboard: every accepted request pushes
// {expected rgb, expected response cycle}; every response strobe pops and checks.
// ROM model: one-cycle registered read, rgb = addr ^ 0xFFF.
// -----------------------------------------------------------------------------
module tb_image_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [11:0] req0_addr = 12'h000;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [11:0] rsp0_rgb;
    logic        req1_valid = 1'b0;
    logic [11:0] req1_addr = 12'h000;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [11:0] rsp1_rgb;
    logic [11:0] rom_address;
    logic [11:0] rom_rgb = 12'h000;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [11:0] rgb;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    image_rom_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_ready  (req0_ready),
        .rsp0_valid  (rsp0_valid),
        .rsp0_rgb    (rsp0_rgb),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_ready  (req1_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_rgb    (rsp1_rgb),
        .rom_address (rom_address),
        .rom_rgb     (rom_rgb)
    );

    always #5 clk = ~clk;

    // Image ROM stand-in: registered read with a recognisable data pattern.
    always @(posedge clk) begin
        rom_rgb <= rom_address ^ 12'hFFF;
        cyc     <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard step, run at the negedge of every cycle.
    task automatic sb();
        exp_t e;
        chk("ready0_without_valid", {31'd0, req0_ready & ~req0_valid}, 32'd0);
        chk("ready1_without_valid", {31'd0, req1_ready & ~req1_valid}, 32'd0);
        if (rsp0_valid === 1'b1) begin
            if (q0.size() == 0) begin
                chk("rsp0_spurious", {31'd0, rsp0_valid}, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("rsp0_rgb", {20'd0, rsp0_rgb}, {20'd0, e.rgb});
                chk("rsp0_cycle", cyc, e.cyc);
            end
        end
        if (rsp1_valid === 1'b1) begin
            if (q1.size() == 0) begin
                chk("rsp1_spurious", {31'd0, rsp1_valid}, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("rsp1_rgb", {20'd0, rsp1_rgb}, {20'd0, e.rgb});
                chk("rsp1_cycle", cyc, e.cyc);
            end
        end
        if (q0.size() > 0 && q0[0].cyc < cyc) begin
            chk("rsp0_missing", cyc, q0[0].cyc);
            void'(q0.pop_front());
        end
        if (q1.size() > 0 && q1[0].cyc < cyc) begin
            chk("rsp1_missing", cyc, q1[0].cyc);
            void'(q1.pop_front());
        end
        if (req0_valid && req0_ready) q0.push_back('{rgb: req0_addr ^ 12'hFFF, cyc: cyc + 2});
        if (req1_valid && req1_ready) q1.push_back('{rgb: req1_addr ^ 12'hFFF, cyc: cyc + 2});
        // A reset sampled at the next edge kills everything still in flight.
        if (rst) begin
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then idle; valid during reset must not be granted.
        rst = 1'b1;
        tick();
        req0_valid = 1'b1;
        req0_addr  = 12'h555;
        #1;
        chk("rst_ready0_forced", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("idle_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("idle_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("idle_rsp0_rgb", {20'd0, rsp0_rgb}, 32'd0);
        chk("idle_rsp1_rgb", {20'd0, rsp1_rgb}, 32'd0);
        chk("idle_rom_address", {20'd0, rom_address}, 32'd0);
        chk("idle_ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        tick();

        // Single requester 0.
        req0_valid = 1'b1;
        req0_addr  = 12'h041;
        #1;
        chk("single_ready0", {31'd0, req0_ready}, 32'd1);
        chk("single_ready1", {31'd0, req1_ready}, 32'd0);
        chk("single_rom_address", {20'd0, rom_address}, 32'h041);
        tick();
        req0_valid = 1'b0;
        req0_addr  = 12'h3C3;
        #1;
        chk("single_addr_hold", {20'd0, rom_address}, 32'h041);
        tick();
        chk("single_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("single_rsp0_rgb", {20'd0, rsp0_rgb}, 32'hFBE);
        chk("single_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        tick();
        chk("single_strobe_one_cycle", {31'd0, rsp0_valid}, 32'd0);
        chk("single_rgb_held", {20'd0, rsp0_rgb}, 32'hFBE);
        tick();

        // Streaming on requester 1.
        req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req1_addr = 12'(i);
            #1;
            chk("stream_ready1", {31'd0, req1_ready}, 32'd1);
            tick();
        end
        req1_valid = 1'b0;
        req1_addr  = 12'hABC;
        for (int i = 0; i < 3; i++) tick();
        chk("stream_addr_hold", {20'd0, rom_address}, 32'h007);
        chk("stream_drained", q1.size(), 32'd0);

        // Contention: requester 1 won last, so grants run 0,1,0,1,...
        req0_valid = 1'b1;
        req0_addr  = 12'h100;
        req1_valid = 1'b1;
        req1_addr  = 12'h200;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cont_ready0", {31'd0, req0_ready}, {31'd0, (i % 2) == 0});
            chk("cont_ready1", {31'd0, req1_ready}, {31'd0, (i % 2) == 1});
            chk("cont_rom_address", {20'd0, rom_address}, ((i % 2) == 0) ? 32'h100 : 32'h200);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Reset mid-flight: accepted read must never come back.
        req0_valid = 1'b1;
        req0_addr  = 12'h0AA;
        #1;
        chk("mid_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mid_no_rsp0", {31'd0, rsp0_valid}, 32'd0);
            tick();
        end
        req0_valid = 1'b1;
        req0_addr  = 12'h111;
        req1_valid = 1'b1;
        req1_addr  = 12'h222;
        #1;
        chk("post_rst_ready0_first", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_ready1_first", {31'd0, req1_ready}, 32'd0);
        tick();
        chk("post_rst_ready1_second", {31'd0, req1_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        chk("final_q0_empty", q0.size(), 32'd0);
        chk("final_q1_empty", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
